// File: rtl/dino_pkg.sv
// Shared constants for the dino game sprite path.
// Holds the sprite ROM geometry, the requester indices used by the ROM arbiter,
// and the base addresses of each sprite bitmap inside the shared ROM.
package dino_pkg;

    // Sprite ROM geometry
    localparam int unsigned SPRITE_ROM_AW  = 9;
    localparam int unsigned SPRITE_ROM_DW  = 8;
    localparam int unsigned SPRITE_ROM_LAT = 1;

    // Requesters sharing the ROM
    localparam int unsigned SPRITE_NREQ = 3;
    localparam int unsigned REQ_DINO    = 0;
    localparam int unsigned REQ_OBS     = 1;
    localparam int unsigned REQ_SCORE   = 2;

    // Sprite bitmap base addresses (one ROM word per sprite row slice)
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_DINO_RUN0 = 9'h000;
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_DINO_RUN1 = 9'h040;
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_DINO_JUMP = 9'h080;
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_CACTUS    = 9'h0c0;
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_BIRD      = 9'h100;
    localparam logic [SPRITE_ROM_AW-1:0] SPR_BASE_DIGITS    = 9'h180;

    // Modulo-n wrap for values known to be below 2*n; avoids relying on
    // power-of-two overflow when n is not a power of two.
    function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with frame-start pointer clear.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   req          - per-requester request vector
//   frame_start  - forces the pointer to 0 at the next edge
//   gnt          - one-hot grant (combinational)
//   gnt_valid    - any grant this cycle
//   gnt_idx      - index of the granted requester
module rr_arbiter
    import dino_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            frame_start,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [PW-1:0]   gnt_idx
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;

    // Search ptr, ptr+1, ... (mod NREQ); first asserted request wins.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'(rr_wrap(32'(ptr_q) + i, NREQ));
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
        // Nothing is accepted while held in reset.
        if (rst) begin
            gnt       = '0;
            gnt_valid = 1'b0;
        end
    end

    // Frame start wins over the post-grant pointer update.
    always_comb begin
        ptr_d = ptr_q;
        if (frame_start) begin
            ptr_d = '0;
        end else if (gnt_valid) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port synchronous sprite ROM between the dino, obstacle and
// score-digit renderers using round-robin arbitration.
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   i_req/i_addr   - per-requester request and address (slice k = [k*AW +: AW])
//   o_gnt          - one-hot grant in the acceptance cycle
//   o_rom_en/addr  - registered ROM read strobe and address
//   i_rom_data     - ROM read data, ROM_LAT clocks after the strobe
//   o_rsp_valid    - one-cycle response pulse per requester
//   o_data         - per-requester held response data (slice k = [k*DW +: DW])
//   i_frame_start  - clears the round-robin pointer
//   o_busy         - any read in flight or response pending
module sprite_rom_arbiter
    import dino_pkg::*;
#(
    parameter int unsigned NREQ    = SPRITE_NREQ,
    parameter int unsigned AW      = SPRITE_ROM_AW,
    parameter int unsigned DW      = SPRITE_ROM_DW,
    parameter int unsigned ROM_LAT = SPRITE_ROM_LAT,
    localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*AW-1:0] i_addr,
    output logic [NREQ-1:0]    o_gnt,
    output logic               o_rom_en,
    output logic [AW-1:0]      o_rom_addr,
    input  logic [DW-1:0]      i_rom_data,
    output logic [NREQ-1:0]    o_rsp_valid,
    output logic [NREQ*DW-1:0] o_data,
    input  logic               i_frame_start,
    output logic               o_busy
);

    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [AW-1:0] gnt_addr;

    logic          rom_en_q;
    logic [AW-1:0] rom_addr_q;

    // Stage j holds a grant made j+1 cycles ago; the last stage lines up with
    // valid ROM data.
    logic          tag_vld_q [0:ROM_LAT];
    logic [IW-1:0] tag_idx_q [0:ROM_LAT];

    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0] data_q, data_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (i_req),
        .frame_start (i_frame_start),
        .gnt         (o_gnt),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx)
    );

    always_comb begin
        gnt_addr = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                gnt_addr = i_addr[k*AW +: AW];
            end
        end
    end

    // Issue registers: address holds its last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_en_q <= gnt_valid;
            if (gnt_valid) begin
                rom_addr_q <= gnt_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j <= ROM_LAT; j++) begin
                tag_vld_q[j] <= 1'b0;
                tag_idx_q[j] <= '0;
            end
        end else begin
            tag_vld_q[0] <= gnt_valid;
            tag_idx_q[0] <= gnt_idx;
            for (int unsigned j = 1; j <= ROM_LAT; j++) begin
                tag_vld_q[j] <= tag_vld_q[j-1];
                tag_idx_q[j] <= tag_idx_q[j-1];
            end
        end
    end

    // Capture ROM data into the owning requester's slice only.
    always_comb begin
        rsp_valid_d = '0;
        data_d      = data_q;
        if (tag_vld_q[ROM_LAT]) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (tag_idx_q[ROM_LAT] == IW'(k)) begin
                    rsp_valid_d[k]       = 1'b1;
                    data_d[k*DW +: DW]   = i_rom_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            data_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        o_busy = |rsp_valid_q;
        for (int unsigned j = 0; j <= ROM_LAT; j++) begin
            o_busy = o_busy | tag_vld_q[j];
        end
    end

    assign o_rom_en    = rom_en_q;
    assign o_rom_addr  = rom_addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_data      = data_q;

endmodule
